// File: rtl/exit_park_pkg.sv
// Shared types and constants for the exit_park parking-exit controller.
package exit_park_pkg;

  localparam int SPACES = 8;
  localparam int IDX_W  = 3;
  localparam int FEE_W  = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_CHECK    = 2'd1;
  localparam state_t ST_OPEN     = 2'd2;
  localparam state_t ST_WAIT_REL = 2'd3;

  function automatic logic [SPACES-1:0] space_mask(input logic [IDX_W-1:0] idx);
    space_mask = {{(SPACES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/exit_park_gate_timer.sv
// Gate hold-open timer: load a cycle count, count down while enabled, flag the last cycle.
module exit_gate_timer #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over decrement; stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(CYCLES);
    end else if (en_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Countdown register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/exit_park.sv
// Parking exit controller: validates exit requests against the occupancy map and drives the gate.
// Optional per-space parking fee is enabled by defining EXIT_FEE_EN.
module exit_park
  import exit_park_pkg::*;
#(
  parameter int SPACES      = 8,
  parameter int GATE_CYCLES = 16
`ifdef EXIT_FEE_EN
  ,
  parameter int TICK_DIV    = 1000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              park_set,
  input  logic [IDX_W-1:0]  park_number,
  input  logic              exit_req,
  input  logic [IDX_W-1:0]  exit_number,
  output logic              exit_ack,
  output logic              exit_err,
  output logic              gate_open,
  output logic [SPACES-1:0] parking_capacity,
  output logic [7:0]        exit_count
`ifdef EXIT_FEE_EN
  ,
  output logic              fee_valid,
  output logic [FEE_W-1:0]  fee
`endif
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   num_q, num_d;
  logic [SPACES-1:0]  cap_q, cap_d, clr_mask_s;
  logic [7:0]         cnt_q, cnt_d;
  logic               ack_q, ack_d, err_q, err_d, gate_q, gate_d;
  logic               load_s, done_s;

  // Exit FSM: decide in CHECK, hold the gate in OPEN, wait for request release.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    gate_d     = gate_q;
    clr_mask_s = {SPACES{1'b0}};
    load_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exit_req) begin
          num_d   = exit_number;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (cap_q[num_q]) begin
          clr_mask_s = space_mask(num_q);
          ack_d      = 1'b1;
          gate_d     = 1'b1;
          load_s     = 1'b1;
          cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d    = ST_OPEN;
        end else begin
          err_d   = 1'b1;
          state_d = ST_WAIT_REL;
        end
      end
      ST_OPEN: begin
        if (done_s) begin
          gate_d  = 1'b0;
          state_d = ST_WAIT_REL;
        end else begin
          state_d = ST_OPEN;
        end
      end
      ST_WAIT_REL: begin
        if (!exit_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_REL;
        end
      end
      default: begin
        gate_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear from the exit path applies before the entry-side set, so a same-bit collision ends occupied.
  always_comb begin
    cap_d = cap_q & ~clr_mask_s;
    if (park_set) begin
      cap_d = cap_d | space_mask(park_number);
    end else begin
      cap_d = cap_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      num_q   <= {IDX_W{1'b0}};
      cap_q   <= {SPACES{1'b0}};
      cnt_q   <= 8'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      gate_q  <= gate_d;
    end
  end

  exit_gate_timer #(.CYCLES(GATE_CYCLES)) u_gate_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_s),
    .en_i   (state_q == ST_OPEN),
    .done_o (done_s)
  );

  assign exit_ack         = ack_q;
  assign exit_err         = err_q;
  assign gate_open        = gate_q;
  assign parking_capacity = cap_q;
  assign exit_count       = cnt_q;

`ifdef EXIT_FEE_EN
  logic [15:0]      pre_q;
  logic             tick_s;
  logic [FEE_W-1:0] fee_cnt_q [SPACES];
  logic [FEE_W-1:0] fee_q;
  logic             fee_valid_q;

  assign tick_s = (pre_q == 16'(TICK_DIV - 1));

  // Free-running prescaler, per-space tick counters and the fee snapshot taken with exit_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= 16'd0;
      fee_q       <= {FEE_W{1'b0}};
      fee_valid_q <= 1'b0;
      for (int i = 0; i < SPACES; i++) begin
        fee_cnt_q[i] <= {FEE_W{1'b0}};
      end
    end else begin
      pre_q       <= tick_s ? 16'd0 : pre_q + 16'd1;
      fee_valid_q <= ack_d;
      fee_q       <= ack_d ? fee_cnt_q[num_q] : fee_q;
      for (int i = 0; i < SPACES; i++) begin
        if (park_set && (park_number == IDX_W'(i))) begin
          fee_cnt_q[i] <= {FEE_W{1'b0}};
        end else if (tick_s && cap_q[i] && (fee_cnt_q[i] != {FEE_W{1'b1}})) begin
          fee_cnt_q[i] <= fee_cnt_q[i] + {{(FEE_W-1){1'b0}}, 1'b1};
        end else begin
          fee_cnt_q[i] <= fee_cnt_q[i];
        end
      end
    end
  end

  assign fee_valid = fee_valid_q;
  assign fee       = fee_q;
`endif

endmodule

// File: tb/tb_exit_park.sv
// Directed and randomized bench for exit_park (default build, fee feature disabled).
module tb_exit_park;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       park_set;
  logic [2:0] park_number;
  logic       exit_req;
  logic [2:0] exit_number;
  logic       exit_ack;
  logic       exit_err;
  logic       gate_open;
  logic [7:0] parking_capacity;
  logic [7:0] exit_count;

  int errors = 0;
  int checks = 0;

  // Reference model: which spaces are taken and how many exits were granted.
  bit occ [8];
  int exits_done;

  exit_park dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .park_set         (park_set),
    .park_number      (park_number),
    .exit_req         (exit_req),
    .exit_number      (exit_number),
    .exit_ack         (exit_ack),
    .exit_err         (exit_err),
    .gate_open        (gate_open),
    .parking_capacity (parking_capacity),
    .exit_count       (exit_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_cap();
    logic [7:0] m;
    m = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (occ[i]) m = m + (8'd1 << i);
    end
    return m;
  endfunction

  function automatic logic [7:0] model_count();
    return (exits_done > 255) ? 8'd255 : 8'(exits_done);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic park(input logic [2:0] n);
    @(posedge clk); #1;
    park_set = 1'b1; park_number = n;
    @(posedge clk); #1;
    park_set = 1'b0;
    occ[n] = 1'b1;
    chk("park_cap", parking_capacity, model_cap());
  endtask

  // One exit request held for 'hold' cycles after the response, optionally colliding with a park.
  task automatic exit_txn(input logic [2:0] n, input logic pin, input logic [2:0] pn, input int hold);
    bit ok;
    int g;
    int extra;
    ok = occ[n];
    @(posedge clk); #1;
    exit_req = 1'b1; exit_number = n;
    @(posedge clk); #1;
    chk("resp_early", {exit_ack, exit_err}, 16'd0);
    if (pin) begin
      park_set = 1'b1; park_number = pn;
    end
    @(posedge clk); #1;
    park_set = 1'b0;
    exit_number = 3'($urandom);
    if (ok) exits_done++;
    occ[n] = 1'b0;
    if (pin) occ[pn] = 1'b1;
    chk("exit_ack", exit_ack, ok);
    chk("exit_err", exit_err, !ok);
    chk("gate_first", gate_open, ok);
    chk("cap_after", parking_capacity, model_cap());
    chk("exit_count", exit_count, model_count());
    g = gate_open ? 1 : 0;
    extra = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (gate_open) g++;
      if (exit_ack || exit_err) extra++;
    end
    chk("gate_cycles", 16'(g), ok ? 16'd16 : 16'd0);
    chk("no_repeat", 16'(extra), 16'd0);
    exit_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; park_set = 1'b0; park_number = 3'd0;
    exit_req = 1'b0; exit_number = 3'd0;
    exits_done = 0;
    for (int i = 0; i < 8; i++) occ[i] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", exit_ack, 1'b0);
    chk("rst_err", exit_err, 1'b0);
    chk("rst_gate", gate_open, 1'b0);
    chk("rst_cap", parking_capacity, 8'h00);
    chk("rst_count", exit_count, 8'h00);
    rst_n = 1'b1;

    // Basic exit, empty-space error, long hold, same-bit collision.
    park(3'd5);
    exit_txn(3'd5, 1'b0, 3'd0, 20);
    exit_txn(3'd2, 1'b0, 3'd0, 20);
    park(3'd1);
    exit_txn(3'd1, 1'b0, 3'd0, 40);
    exit_txn(3'd1, 1'b0, 3'd0, 20);
    park(3'd3);
    exit_txn(3'd3, 1'b1, 3'd3, 20);
    chk("collide_bit3", parking_capacity[3], 1'b1);
    park(3'd7);
    exit_txn(3'd7, 1'b1, 3'd0, 20);

    // Reset in the middle of the gate-open window, with a request held across release.
    park(3'd6);
    @(posedge clk); #1;
    exit_req = 1'b1; exit_number = 3'd6;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_ack", exit_ack, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_gate", gate_open, 1'b1);
    rst_n = 1'b0;
    exit_number = 3'd4;
    #1;
    chk("midrst_gate", gate_open, 1'b0);
    chk("midrst_cap", parking_capacity, 8'h00);
    chk("midrst_count", exit_count, 8'h00);
    for (int i = 0; i < 8; i++) occ[i] = 1'b0;
    exits_done = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("post_rst_err", exit_err, 1'b1);
    chk("post_rst_ack", exit_ack, 1'b0);
    exit_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;

    // Randomized mix of parks and exits.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        park(3'($urandom));
      end else begin
        exit_txn(3'($urandom), 1'($urandom), 3'($urandom), 18);
      end
    end

    // Drive the exit counter past its ceiling.
    for (int k = 0; k < 260; k++) begin
      park(3'(k));
      exit_txn(3'(k), 1'b0, 3'd0, 17);
    end
    chk("count_sat", exit_count, 8'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
